// File: rtl/pong_pkg.sv
// Shared geometry, derived limits and state encodings for the pong game-logic stage.
package pong_pkg;

  localparam int unsigned H_ACTIVE    = 640;
  localparam int unsigned V_ACTIVE    = 480;
  localparam int unsigned BALL_SIZE   = 8;
  localparam int unsigned BALL_STEP   = 2;
  localparam int unsigned PADDLE_HALF = 10;
  localparam int unsigned P1_FACE     = 32;
  localparam int unsigned P2_FACE     = 600;
  localparam int unsigned WIN_SCORE   = 10;
  localparam int unsigned SERVE_TICKS = 32;

  // State values drive the status LEDs directly, so they must stay fixed.
  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_SERVE = 2'b01;
  localparam logic [1:0] ST_PLAY  = 2'b10;
  localparam logic [1:0] ST_DONE  = 2'b11;

  localparam logic [9:0] CX         = 10'((H_ACTIVE - BALL_SIZE) / 2);
  localparam logic [9:0] CY         = 10'((V_ACTIVE - BALL_SIZE) / 2);
  localparam logic [9:0] STEP       = 10'(BALL_STEP);
  localparam logic [9:0] Y_MAX      = 10'(V_ACTIVE - BALL_SIZE);
  localparam logic [9:0] Y_DN_LIM   = 10'(V_ACTIVE - BALL_SIZE - BALL_STEP);
  localparam logic [9:0] X_P1_STOP  = 10'(P1_FACE);
  localparam logic [9:0] X_L_LIM    = 10'(P1_FACE + BALL_STEP);
  localparam logic [9:0] X_P2_STOP  = 10'(P2_FACE - BALL_SIZE);
  localparam logic [9:0] X_R_LIM    = 10'(P2_FACE - BALL_SIZE - BALL_STEP);
  localparam logic [4:0] SERVE_LAST = 5'(SERVE_TICKS - 1);
  localparam logic [3:0] WIN_SC     = 4'(WIN_SCORE);

  // Additions only, in 11 bits, so a paddle near the top edge cannot wrap.
  function automatic logic paddle_hit(logic [9:0] y, logic [9:0] pos);
    return (({1'b0, y} + 11'(BALL_SIZE + PADDLE_HALF)) > {1'b0, pos}) &&
           ({1'b0, y} <= ({1'b0, pos} + 11'(PADDLE_HALF)));
  endfunction

endpackage

// File: rtl/pong_ball_step.sv
// Combinational one-tick ball motion: wall bounce, paddle bounce and miss detection.
import pong_pkg::*;

module pong_ball_step (
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic       dx,
  input  logic       dy,
  input  logic [9:0] p1_pos,
  input  logic [9:0] p2_pos,
  output logic [9:0] next_x,
  output logic [9:0] next_y,
  output logic       next_dx,
  output logic       next_dy,
  output logic       miss_left,
  output logic       miss_right
);

  // dx: 1 = moving right; dy: 1 = moving down.
  always_comb begin
    next_x     = x;
    next_y     = y;
    next_dx    = dx;
    next_dy    = dy;
    miss_left  = 1'b0;
    miss_right = 1'b0;

    if (dy) begin
      if (y >= Y_DN_LIM) begin
        next_y  = Y_MAX;
        next_dy = 1'b0;
      end else begin
        next_y = y + STEP;
      end
    end else begin
      if (y <= STEP) begin
        next_y  = '0;
        next_dy = 1'b1;
      end else begin
        next_y = y - STEP;
      end
    end

    if (!dx) begin
      if (x > X_L_LIM) begin
        next_x = x - STEP;
      end else if (paddle_hit(y, p1_pos)) begin
        next_x  = X_P1_STOP;
        next_dx = 1'b1;
      end else begin
        miss_left = 1'b1;
      end
    end else begin
      if (x < X_R_LIM) begin
        next_x = x + STEP;
      end else if (paddle_hit(y, p2_pos)) begin
        next_x  = X_P2_STOP;
        next_dx = 1'b0;
      end else begin
        miss_right = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game FSM: serve countdown, play, scoring and game-over hold.
import pong_pkg::*;

module pong_game_ctrl (
  input  logic       board_clk,
  input  logic       reset,
  input  logic       start,
  input  logic       tick,
  input  logic [9:0] p1_pos,
  input  logic [9:0] p2_pos,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic [3:0] p1_score,
  output logic [3:0] p2_score,
  output logic [1:0] state,
  output logic       point,
  output logic       point_p2
);

  logic       dx;
  logic       dy;
  logic [4:0] serve_cnt;
  logic [9:0] next_x;
  logic [9:0] next_y;
  logic       next_dx;
  logic       next_dy;
  logic       miss_left;
  logic       miss_right;

  pong_ball_step u_step (
    .x          (ball_x),
    .y          (ball_y),
    .dx         (dx),
    .dy         (dy),
    .p1_pos     (p1_pos),
    .p2_pos     (p2_pos),
    .next_x     (next_x),
    .next_y     (next_y),
    .next_dx    (next_dx),
    .next_dy    (next_dy),
    .miss_left  (miss_left),
    .miss_right (miss_right)
  );

  function automatic logic [3:0] sat_inc(logic [3:0] s);
    return (s == WIN_SC) ? s : s + 4'd1;
  endfunction

  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      p1_score  <= '0;
      p2_score  <= '0;
      ball_x    <= CX;
      ball_y    <= CY;
      dx        <= 1'b0;
      dy        <= 1'b1;
      serve_cnt <= '0;
      point     <= 1'b0;
      point_p2  <= 1'b0;
    end else begin
      point    <= 1'b0;
      point_p2 <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_SERVE;
            p1_score  <= '0;
            p2_score  <= '0;
            ball_x    <= CX;
            ball_y    <= CY;
            serve_cnt <= '0;
            dx        <= 1'b0;
          end
        end
        ST_SERVE: begin
          if (!start) begin
            state     <= ST_IDLE;
            ball_x    <= CX;
            ball_y    <= CY;
            serve_cnt <= '0;
          end else if (tick) begin
            if (serve_cnt == SERVE_LAST) begin
              state     <= ST_PLAY;
              serve_cnt <= '0;
            end else begin
              serve_cnt <= serve_cnt + 5'd1;
            end
          end
        end
        ST_PLAY: begin
          if (!start) begin
            state  <= ST_IDLE;
            ball_x <= CX;
            ball_y <= CY;
          end else if (tick) begin
            if (miss_left || miss_right) begin
              // Serve goes toward the player who just lost; dy keeps its pre-tick value.
              point    <= 1'b1;
              point_p2 <= miss_left;
              ball_x   <= CX;
              ball_y   <= CY;
              dx       <= miss_right;
              if (miss_left) begin
                p2_score <= sat_inc(p2_score);
                state    <= (sat_inc(p2_score) == WIN_SC) ? ST_DONE : ST_SERVE;
              end else begin
                p1_score <= sat_inc(p1_score);
                state    <= (sat_inc(p1_score) == WIN_SC) ? ST_DONE : ST_SERVE;
              end
            end else begin
              ball_x <= next_x;
              ball_y <= next_y;
              dx     <= next_dx;
              dy     <= next_dy;
            end
          end
        end
        ST_DONE: begin
          if (!start) state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
